// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file for the sequential Y86-64 core.
// Commits execute/memory results, serves decode operand reads, and halts on any non-AOK status.
module wb_regfile #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 15,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              cnd,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic [2:0]        stat_in,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] valA_out,
  output logic [DATA_W-1:0] valB_out,
  output logic [2:0]        stat_out,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [3:0] RNONE     = 4'hF;
  localparam logic [3:0] RSP       = 4'h4;
  localparam logic [3:0] REG_LIMIT = 4'(NUM_REGS);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic {
    RUN,
    HALTED
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [2:0]          r_stat;
  logic                r_halted;
  logic [CNT_W-1:0]    r_retired;

  logic [3:0]          w_dstE;
  logic [3:0]          w_dstM;
  logic                w_unusedIfun;

  // cmov gating is already folded into cnd, so ifun carries no decode information here
  assign w_unusedIfun = ^ifun;

  always_comb begin
    w_dstE = RNONE;
    w_dstM = RNONE;
    case (icode)
      I_RRMOVQ:                 if (cnd) w_dstE = rB;
      I_IRMOVQ, I_OPQ:          w_dstE = rB;
      I_CALL, I_RET, I_PUSHQ:   w_dstE = RSP;
      I_POPQ: begin
        w_dstE = RSP;
        w_dstM = rA;
      end
      I_MRMOVQ:                 w_dstM = rA;
      default: ;
    endcase
  end

  // No write bypass: a register written on this edge is only visible to decode next cycle
  assign valA_out = (srcA < REG_LIMIT) ? r_regs[srcA] : '0;
  assign valB_out = (srcB < REG_LIMIT) ? r_regs[srcB] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_state   <= RUN;
      r_stat    <= STAT_AOK;
      r_halted  <= 1'b0;
      r_retired <= '0;
    end else if (wb_valid && r_state == RUN) begin
      if (stat_in != STAT_AOK) begin
        r_stat   <= stat_in;
        r_state  <= HALTED;
        r_halted <= 1'b1;
      end else if (icode == I_HALT) begin
        r_stat   <= STAT_HLT;
        r_state  <= HALTED;
        r_halted <= 1'b1;
      end else if (icode > I_POPQ) begin
        r_stat   <= STAT_INS;
        r_state  <= HALTED;
        r_halted <= 1'b1;
      end else begin
        // The M write is issued last so it wins when popq targets %rsp
        if (w_dstE < REG_LIMIT) r_regs[w_dstE] <= valE;
        if (w_dstM < REG_LIMIT) r_regs[w_dstM] <= valM;
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  assign stat_out = r_stat;
  assign halted   = r_halted;
  assign retired  = r_retired;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback stage and architectural register file for the sequential Y86-64 core.
- Consumes execute outputs (valE, cnd) and memory output (valM) and commits them to the register file.
- Serves combinational operand reads to decode (valA/valB).
- Tracks processor status (AOK/HLT/ADR/INS) and halts commits sticky on any non-AOK status.

Parameters:
DATA_W, 64, register/data width
NUM_REGS, 15, architectural registers r0..r14 (id 4'hF = RNONE)
CNT_W, 32, retired-instruction counter width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
wb_valid  input  1  commit strobe; one instruction per asserted cycle
icode  input  4  instruction code of committing instruction
ifun  input  4  function code (informational; cmov gating uses cnd)
rA  input  4  rA field
rB  input  4  rB field
cnd  input  1  condition result from execute
valE  input  DATA_W  execute result
valM  input  DATA_W  memory read result
stat_in  input  3  status from fetch/memory: 1 AOK, 2 HLT, 3 ADR, 4 INS
srcA  input  4  decode read address A
srcB  input  4  decode read address B
valA_out  output  DATA_W  register[srcA], 0 if srcA=F
valB_out  output  DATA_W  register[srcB], 0 if srcB=F
stat_out  output  3  latched processor status
halted  output  1  high in HALTED state
retired  output  CNT_W  count of committed AOK instructions

Behaviour:
- Reset (rst_n=0, async): all 15 registers = 0, stat_out = 1 (AOK), halted = 0, retired = 0, state = RUN. Takes effect immediately, including mid-stream.
- FSM states: RUN, HALTED. HALTED is sticky until reset; in HALTED wb_valid is ignored (no writes, counter frozen).
- Destination decode (combinational from icode/rA/rB/cnd):
  - dstE = rB for icode 2 only when cnd=1 (rrmovq requires cnd=1, which execute guarantees); otherwise F for icode 2.
  - dstE = rB for icode 3 and 6.
  - dstE = 4 (%rsp) for icode 8, 9, A, B.
  - dstE = F for all other icodes.
  - dstM = rA for icode 5 and B; otherwise F.
- Commit on posedge when wb_valid=1 and state=RUN:
  - stat_in != 1: no register write, stat_out <= stat_in, state -> HALTED, retired unchanged.
  - stat_in = 1 and icode = 0 (halt): no write, stat_out <= 2, state -> HALTED, retired unchanged.
  - stat_in = 1 and icode > 4'hB: no write, stat_out <= 4 (INS), state -> HALTED.
  - Otherwise: write valE to dstE and valM to dstM (writes to id F are dropped), retired += 1, wrapping modulo 2^CNT_W.
- dstE == dstM collision (popq %rsp): valM wins.
- Reads are combinational. A read in the same cycle as a write to the same register returns the old value; the new value is visible the cycle after the edge (no bypass; SEQ timing).
- wb_valid=0: no state change.

Test Plan:
1. Assert rst_n=0 asynchronously mid-cycle -> valA_out/valB_out = 0 for all srcA/srcB, stat_out=1, halted=0, retired=0 immediately, without waiting for a clock edge.
2. OPq: icode=6, rB=3, valE=0x60 (92+4), wb_valid=1 -> after the edge, srcA=3 gives valA_out=0x60 and retired=1. In the same cycle before the edge, srcA=3 reads 0.
3. cmovle not-taken, then cmovg taken: icode=2, ifun=1, rB=5, cnd=0, valE=0x456 -> r5 stays 0. Then icode=2, ifun=6, cnd=1, valE=0x666 -> r5=0x666, retired increments for both commits.
4. popq %rsp: icode=B, rA=4, valE=0x108, valM=0xABC -> r4=0xABC.
   Follow with pushq: icode=A, valE=0x100 -> r4=0x100.
5. Halt and ADR:
   - icode=0, stat_in=1 -> stat_out=2, halted=1; a subsequent irmovq (icode=3, rB=1, valE=7) leaves r1=0 and retired frozen.
   - Separate run: stat_in=3 on a mrmovq -> stat_out=3, no write to rA.
6. Invalid icode and recovery: icode=4'hC, stat_in=1 -> stat_out=4, halted=1. Then pulse rst_n low -> all state cleared, and a new irmovq commits normally.
